// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle arithmetic units: operand width, counter width,
// the common 2-bit state encoding, and a two's-complement magnitude helper.
package div_unit_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_t;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, combinational (zero latency).
// No flow control; the owning FSM decides when the result is registered.
module div_step #(
    parameter int WIDTH = div_unit_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nextRem,
    output logic [WIDTH-1:0] nextQuo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor <= 2^(WIDTH-1) keeps the shifted value inside WIDTH+1 bits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign nextRem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign nextQuo = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider: quotient to Lo, remainder to Hi; done follows start by WIDTH+1 edges, or at once for /0.
// No backpressure: the control unit waits on div_done; starts outside IDLE are dropped.
module div_unit #(
    parameter int WIDTH = div_unit_pkg::WIDTH,
    parameter int CNT_W = div_unit_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_zero
);

    import div_unit_pkg::*;

    divState_t        state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;
    logic [CNT_W-1:0] cnt;
    logic             sq;
    logic             sr;

    div_step #(
        .WIDTH(WIDTH)
    ) stepUnit (
        .rem    (rem),
        .quo    (quo),
        .divisor(divisor),
        .nextRem(nextRem),
        .nextQuo(nextQuo)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            sq       <= 1'b0;
            sr       <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        div_busy <= 1'b1;
                        if (b_in == '0) begin
                            // Results are left untouched so Hi/Lo keep the previous quotient.
                            div_zero <= 1'b1;
                            div_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            quo      <= magnitude(a_in);
                            divisor  <= magnitude(b_in);
                            rem      <= '0;
                            cnt      <= '0;
                            sq       <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            sr       <= a_in[WIDTH-1];
                            div_zero <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= nextRem;
                    quo <= nextQuo;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_out   <= sq ? -quo : quo;
                    hi_out   <= sr ? -rem : rem;
                    div_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    div_done <= 1'b0;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
